multicycle_controller: RTL
==========================

# multicycle_controller

Control FSM for the multicycle RV32I datapath. It sequences fetch, decode, execute, memory and writeback, and drives the ALU operation code and the datapath select/enable lines. It consumes the ALU's `zero`, `lt` and `bge` flags to resolve branches. It sits between the instruction register (op/funct fields) and the datapath muxes/enables; the ALU is the other end of its `ALUControl` / flag interface.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  the single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `op`  in  7  instruction opcode, `instr[6:0]`.
- `funct3`  in  3  `instr[14:12]`.
- `funct7b5`  in  1  `instr[30]`.
- `zero`, `lt`, `bge`  in  1 each  ALU comparison flags of `SrcA` vs `SrcB`.
- `ALUControl`  out  3  ALU opcode:
  - 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu.
- `ALUSrcA`  out  2  00 PC, 01 OldPC, 10 RD1.
- `ALUSrcB`  out  2  00 RD2, 01 ImmExt, 10 constant 4.
- `ResultSrc`  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt.
- `ImmSrc`  out  3  0 I, 1 S, 2 B, 3 J, 4 U.
- `AdrSrc`  out  1  0 PC, 1 Result.
- `IRWrite`, `MemWrite`, `RegWrite`, `PCWrite`  out  1 each  write enables.
- `illegal`  out  1  sticky illegal-instruction flag.

## Operation
All outputs are decoded from the state (Moore). The one exception is `PCWrite` in BRANCH, which also depends on the flags.

Unlisted outputs in any state are 0. ALUSrcA/B=00 unless stated.

States:
- **FETCH**
  - Outputs: AdrSrc=0, IRWrite=1, ALUSrcB=10, add, ResultSrc=10, PCWrite=1.
  - Next: DECODE.
- **DECODE**
  - Outputs: ALUSrcA=01, ALUSrcB=01, add. ImmSrc=J if op=1101111, else B.
  - Next, by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR1
    - 0110111 → LUI
    - anything else → illegal handling (see Configuration).
- **MEMADR**
  - Outputs: ALUSrcA=10, ALUSrcB=01, add. ImmSrc=S if op[5] is set, else I.
  - Next: MEMWRITE if op[5], else MEMREAD.
- **MEMREAD**: AdrSrc=1, ResultSrc=00. Next: MEMWB.
- **MEMWB**: ResultSrc=01, RegWrite=1. Next: FETCH.
- **MEMWRITE**: AdrSrc=1, ResultSrc=00, MemWrite=1. Next: FETCH.
- **EXECR**: ALUSrcA=10, ALUSrcB=00, decoded op. Next: ALUWB.
- **EXECI**: ALUSrcA=10, ALUSrcB=01, ImmSrc=I, decoded op. Next: ALUWB.
- **ALUWB**: ResultSrc=00, RegWrite=1. Next: FETCH.
- **BRANCH**
  - Outputs: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=taken.
  - Next: FETCH.
- **JAL**: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Next: ALUWB.
- **JALR1**: ALUSrcA=10, ALUSrcB=01, ImmSrc=I, add. Next: JALR2.
- **JALR2**: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Next: ALUWB.
- **LUI**: ImmSrc=4, ResultSrc=11, RegWrite=1. Next: FETCH.

Decoded op (by funct3):
- 000: sub if op=0110011 and funct7b5=1, else add.
- 010: slt.
- 011: sltu.
- 100: xor.
- 110: or.
- 111: and.
- 001, 101: unsupported.

Branch taken (by funct3):
- 000: `zero`.
- 001: `!zero`.
- 100: `lt`.
- 101: `bge`.
- 010, 011, 110, 111: unsupported, never taken.

Unsupported funct3 is detected in DECODE, together with the opcode check.

## Timing
- Reset:
  - State forced to FETCH.
  - IRWrite, MemWrite, RegWrite, PCWrite forced 0 while `rst`=1.
  - `illegal`=0.
  - Remaining outputs show FETCH values.
  - The first fetch is the cycle after `rst` falls.
- Cycles per instruction, FETCH to next FETCH:
  - lw 5
  - sw 4
  - R/I-ALU 4
  - branch 3
  - jal 4
  - jalr 5
  - lui 3
- Flags are sampled combinationally in BRANCH only; flag values in other states are ignored.
- `rst` asserted in any state: the next state is FETCH and no write enable is asserted in that cycle.

## Configuration
- `ILLEGAL_TRAP_EN` defined:
  - An unsupported opcode, or unsupported funct3 on R/I/branch, sends DECODE to state ERROR.
  - ERROR holds all enables at 0 and sets `illegal`=1.
  - ERROR is left only by `rst`.
- `ILLEGAL_TRAP_EN` undefined:
  - An unsupported opcode returns DECODE to FETCH, so the instruction acts as a NOP.
  - Unsupported ALU funct3 executes as add; unsupported branch funct3 is never taken.
  - `illegal` is tied to 0.

## Test plan
- **Reset:** `rst`=1 for 2 cycles, then op=0110011, funct3=000, funct7b5=1.
  - Next 4 cycles: FETCH (PCWrite=1, IRWrite=1) → DECODE → EXECR (ALUControl=1) → ALUWB (RegWrite=1).
- **lw, then sw:**
  - op=0000011 → MEMREAD has AdrSrc=1; MEMWB has ResultSrc=01, RegWrite=1; 5 cycles total.
  - op=0100011 → MEMWRITE=1 in the 4th cycle; MEMADR shows ImmSrc=1.
- **Branches:** in BRANCH,
  - beq with zero=1 → PCWrite=1.
  - bne with zero=1 → PCWrite=0.
  - blt with lt=1 → PCWrite=1.
  - bge with bge=0 → PCWrite=0.
- **I-type ALU:** op=0010011 in EXECI.
  - funct3=010 → ALUControl=5.
  - funct3=011 → ALUControl=6.
  - funct3=000 with funct7b5=1 → ALUControl=0.
- **Jumps and lui:**
  - jal: DECODE ImmSrc=3; JAL has PCWrite=1; ALUWB has RegWrite=1.
  - jalr: JALR1 then JALR2 (PCWrite=1), 5 cycles total.
  - lui: LUI has ResultSrc=3, ImmSrc=4, RegWrite=1.
- **Illegal op=1111111:**
  - With the macro: ERROR with `illegal`=1 held for 10 cycles; after `rst`, back to FETCH with `illegal`=0.
  - Without the macro: back to FETCH the cycle after DECODE.

Source files
------------

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I datapath: sequences fetch/decode/execute/memory/writeback.
// Define ILLEGAL_TRAP_EN to trap unsupported instructions in a sticky ERROR state.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       lt,
  input  logic       bge,
  output logic [2:0] ALUControl,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ImmSrc,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       PCWrite,
  output logic       illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_SLT  = 3'd5;
  localparam logic [2:0] ALU_SLTU = 3'd6;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR1, S_JALR2,
    S_LUI, S_ERROR
  } state_t;

  state_t     state, next_state, out_state;
  logic [2:0] alu_dec;
  logic       taken;
  logic       alu_f3_ok, br_f3_ok;

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  always_comb begin
    alu_dec = ALU_ADD;
    case (funct3)
      3'b000:  alu_dec = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b011:  alu_dec = ALU_SLTU;
      3'b100:  alu_dec = ALU_XOR;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = bge;
      default: taken = 1'b0;
    endcase
  end

  assign alu_f3_ok = (funct3 != 3'b001) && (funct3 != 3'b101);
  assign br_f3_ok  = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                     (funct3 == 3'b100) || (funct3 == 3'b101);

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:    next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_R:              next_state = S_EXECR;
          OP_I:              next_state = S_EXECI;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR1;
          OP_LUI:            next_state = S_LUI;
`ifdef ILLEGAL_TRAP_EN
          default:           next_state = S_ERROR;
`else
          default:           next_state = S_FETCH;
`endif
        endcase
`ifdef ILLEGAL_TRAP_EN
        if (((op == OP_R || op == OP_I) && !alu_f3_ok) ||
            (op == OP_BRANCH && !br_f3_ok))
          next_state = S_ERROR;
`endif
      end
      S_MEMADR:   next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  next_state = S_MEMWB;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: next_state = S_FETCH;
      S_EXECR:    next_state = S_ALUWB;
      S_EXECI:    next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_BRANCH:   next_state = S_FETCH;
      S_JAL:      next_state = S_ALUWB;
      S_JALR1:    next_state = S_JALR2;
      S_JALR2:    next_state = S_ALUWB;
      S_LUI:      next_state = S_FETCH;
      S_ERROR:    next_state = S_ERROR;
      default:    next_state = S_FETCH;
    endcase
  end

  // While reset is held the outputs present FETCH with every write enable suppressed.
  assign out_state = rst ? S_FETCH : state;

  always_comb begin
    ALUControl = ALU_ADD;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ImmSrc     = 3'd0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    PCWrite    = 1'b0;
    case (out_state)
      S_FETCH: begin
        IRWrite = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; PCWrite = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_JAL) ? 3'd3 : 3'd2;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01;
        ImmSrc  = op[5] ? 3'd1 : 3'd0;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01; RegWrite = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1; MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10; ALUControl = alu_dec;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUControl = alu_dec;
      end
      S_ALUWB:    RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA = 2'b10; ALUControl = ALU_SUB; PCWrite = taken;
      end
      S_JAL, S_JALR2: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; PCWrite = 1'b1;
      end
      S_JALR1: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01;
      end
      S_LUI: begin
        ImmSrc = 3'd4; ResultSrc = 2'b11; RegWrite = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      PCWrite  = 1'b0;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  assign illegal = (out_state == S_ERROR);
`else
  assign illegal = 1'b0;
`endif

endmodule
